// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//
// Serialises 12-bit DAC codes into 16-bit SPI write frames for an
// MCP4921-style serial DAC. Each accepted code becomes the frame
// {CFG_BITS, sample}, which is shifted out MSB first with SPI mode 0 timing
// (SCLK idles low and the DAC samples MOSI on the rising edge).
//
// Frame sequence: IDLE -> SETUP -> SHIFT (16 bits) -> HOLD -> [LDAC] -> GAP.
// SETUP, HOLD, LDAC and GAP each last CLK_DIV cycles. Each SCLK high phase
// and each SCLK low phase also lasts CLK_DIV cycles.
//
// Optional feature macro: DAC_SPI_TX_LDAC_EN
//   defined   : LDAC state present; dac_ldac_n_o pulses low for CLK_DIV
//               cycles right after CS_n rises.
//   undefined : no LDAC state; dac_ldac_n_o is tied low, so the DAC updates
//               on the CS_n rising edge.
//
// Parameters:
//   CLK_DIV  - SCLK half-period in sys_clk_i cycles (1..255, 0 is illegal)
//   CFG_BITS - command nibble sent ahead of the 12 data bits
//
// Ports:
//   sys_clk_i      - system clock, rising edge
//   sys_rst_n_i    - asynchronous active-low reset
//   sample_i       - 12-bit DAC code
//   sample_valid_i - sample_i is valid
//   sample_ready_o - block can accept a sample (only in IDLE)
//   busy_o         - frame in progress (any state other than IDLE)
//   dac_sclk_o     - SPI clock
//   dac_cs_n_o     - SPI chip select, active low
//   dac_mosi_o     - SPI data, MSB first
//   dac_ldac_n_o   - DAC latch strobe, active low
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module dac_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic [11:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        busy_o,
  output logic        dac_sclk_o,
  output logic        dac_cs_n_o,
  output logic        dac_mosi_o,
  output logic        dac_ldac_n_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LDAC  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q,   state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q,   shift_d;
  logic        sclk_q,    sclk_d;
  logic        cs_n_q,    cs_n_d;
  logic        mosi_q,    mosi_d;
  logic        ready_q,   ready_d;
  logic        busy_q,    busy_d;
  logic        div_last;

  // Every non-IDLE phase ends when the half-period counter reaches CLK_DIV-1.
  assign div_last = (div_cnt_q == DIV_LAST);

`ifdef DAC_SPI_TX_LDAC_EN
  logic ldac_n_q, ldac_n_d;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 5'd0;
      shift_q   <= 16'd0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

`ifdef DAC_SPI_TX_LDAC_EN
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      ldac_n_q <= 1'b1;
    end else begin
      ldac_n_q <= ldac_n_d;
    end
  end
`endif

  // Next-state logic also computes the next value of every output flop, so
  // each output changes on the same edge as the state it belongs to.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
`ifdef DAC_SPI_TX_LDAC_EN
    ldac_n_d  = ldac_n_q;
`endif

    if (state_q != ST_IDLE) begin
      div_cnt_d = div_last ? 8'd0 : div_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample_valid_i && ready_q) begin
          state_d   = ST_SETUP;
          shift_d   = {CFG_BITS, sample_i};
          mosi_d    = CFG_BITS[3];
          cs_n_d    = 1'b0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          div_cnt_d = 8'd0;
          bit_cnt_d = 5'd0;
        end
      end

      ST_SETUP: begin
        if (div_last) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (div_last) begin
          if (sclk_q) begin
            // Falling SCLK edge: present the next bit, except after the
            // last bit, where MOSI keeps its value through HOLD.
            sclk_d = 1'b0;
            if (bit_cnt_q != 5'd15) begin
              mosi_d  = shift_q[14];
              shift_d = {shift_q[14:0], 1'b0};
            end
          end else if (bit_cnt_q == 5'd15) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_HOLD: begin
        if (div_last) begin
          cs_n_d  = 1'b1;
`ifdef DAC_SPI_TX_LDAC_EN
          state_d  = ST_LDAC;
          ldac_n_d = 1'b0;
`else
          state_d  = ST_GAP;
`endif
        end
      end

`ifdef DAC_SPI_TX_LDAC_EN
      ST_LDAC: begin
        if (div_last) begin
          state_d  = ST_GAP;
          ldac_n_d = 1'b1;
        end
      end
`endif

      ST_GAP: begin
        if (div_last) begin
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
          shift_d   = 16'd0;
          bit_cnt_d = 5'd0;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_d   = ST_IDLE;
        div_cnt_d = 8'd0;
        bit_cnt_d = 5'd0;
        shift_d   = 16'd0;
        sclk_d    = 1'b0;
        cs_n_d    = 1'b1;
        mosi_d    = 1'b0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign sample_ready_o = ready_q;
  assign busy_o         = busy_q;
  assign dac_sclk_o     = sclk_q;
  assign dac_cs_n_o     = cs_n_q;
  assign dac_mosi_o     = mosi_q;
`ifdef DAC_SPI_TX_LDAC_EN
  assign dac_ldac_n_o   = ldac_n_q;
`else
  assign dac_ldac_n_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_tx
//
// Four DUT instances with CLK_DIV = 2, 1, 3 and 255, each with its own
// reset, sample and valid. All inputs are driven and all outputs observed
// on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_dac_spi_tx;

`ifdef DAC_SPI_TX_LDAC_EN
  localparam bit LDAC_EN = 1'b1;
`else
  localparam bit LDAC_EN = 1'b0;
`endif
  localparam int FRAME = LDAC_EN ? 36 : 35;

  logic        clk;
  logic        rst_n [4];
  logic [11:0] smp   [4];
  logic        vld   [4];
  logic        rdy   [4];
  logic        bsy   [4];
  logic        sclk  [4];
  logic        csn   [4];
  logic        mosi  [4];
  logic        ldn   [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(2)) u_dut0 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n[0]), .sample_i(smp[0]),
    .sample_valid_i(vld[0]), .sample_ready_o(rdy[0]), .busy_o(bsy[0]),
    .dac_sclk_o(sclk[0]), .dac_cs_n_o(csn[0]), .dac_mosi_o(mosi[0]),
    .dac_ldac_n_o(ldn[0]));

  dac_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n[1]), .sample_i(smp[1]),
    .sample_valid_i(vld[1]), .sample_ready_o(rdy[1]), .busy_o(bsy[1]),
    .dac_sclk_o(sclk[1]), .dac_cs_n_o(csn[1]), .dac_mosi_o(mosi[1]),
    .dac_ldac_n_o(ldn[1]));

  dac_spi_tx #(.CLK_DIV(3)) u_dut2 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n[2]), .sample_i(smp[2]),
    .sample_valid_i(vld[2]), .sample_ready_o(rdy[2]), .busy_o(bsy[2]),
    .dac_sclk_o(sclk[2]), .dac_cs_n_o(csn[2]), .dac_mosi_o(mosi[2]),
    .dac_ldac_n_o(ldn[2]));

  dac_spi_tx #(.CLK_DIV(255)) u_dut3 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n[3]), .sample_i(smp[3]),
    .sample_valid_i(vld[3]), .sample_ready_o(rdy[3]), .busy_o(bsy[3]),
    .dac_sclk_o(sclk[3]), .dac_cs_n_o(csn[3]), .dac_mosi_o(mosi[3]),
    .dac_ldac_n_o(ldn[3]));

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents a sample with valid high.
  // Called on a falling edge; the transfer happens on the next rising edge.
  task automatic start(input int k, input logic [11:0] s);
    int t;
    t = 0;
    while (!rdy[k] && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check_val($sformatf("ready_wait%0d", k), 32'(rdy[k]), 32'd1);
    smp[k] = s;
    vld[k] = 1'b1;
  endtask

  // Observes one frame after the transfer edge. Observation n is taken on
  // the falling edge after rising edge n (edge 1 = transfer edge).
  // hold: keep valid high and present nxt when ready returns.
  // abort_at: if > 0, assert reset on that SCLK rising edge.
  task automatic monitor(input int k, input int div, input logic [15:0] exp_w,
                         input bit hold, input logic [11:0] nxt,
                         input int abort_at);
    logic [15:0] word;
    logic        prev;
    bit          done;
    int rises, cs_low, cs_last, ld_low, ld_first, busy_n, lat;
    int hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, limit;
    word = 16'd0; prev = 1'b0; done = 1'b0;
    rises = 0; cs_low = 0; cs_last = 0; ld_low = 0; ld_first = 0;
    busy_n = 0; lat = -1; hi_run = 0; lo_run = 0;
    hi_min = 999999; hi_max = 0; lo_min = 999999; lo_max = 0;
    limit = 40 * div + 10;
    for (int n = 1; n <= limit && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        smp[k] = ~smp[k];  // mid-frame change must not matter
        if (!hold) vld[k] = 1'b0;
      end
      if (sclk[k]) begin
        if (!prev) begin
          rises++;
          word = {word[14:0], mosi[k]};
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
          lo_run = 0;
        end
        hi_run++;
      end else begin
        if (prev) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          hi_run = 0;
        end
        if (!csn[k]) lo_run++;
      end
      prev = sclk[k];
      if (abort_at > 0 && rises == abort_at) begin
        rst_n[k] = 1'b0;
        #1;
        check_val("abort_cs_n",  32'(csn[k]),  32'd1);
        check_val("abort_sclk",  32'(sclk[k]), 32'd0);
        check_val("abort_ready", 32'(rdy[k]),  32'd1);
        check_val("abort_busy",  32'(bsy[k]),  32'd0);
        check_val("abort_mosi",  32'(mosi[k]), 32'd0);
        $display("abort dut%0d at sclk rise %0d", k, rises);
        return;
      end
      if (!csn[k]) begin cs_low++; cs_last = n; end
      if (!ldn[k]) begin ld_low++; if (ld_first == 0) ld_first = n; end
      if (bsy[k]) busy_n++;
      if (rdy[k]) begin
        lat  = n - 1;
        done = 1'b1;
        if (hold) smp[k] = nxt;
      end
    end
    check_val("frame_done", 32'(done), 32'd1);
    check_val("frame_word", 32'(word), 32'(exp_w));
    check_val("sclk_rises", 32'(rises), 32'd16);
    check_val("cs_low_cyc", 32'(cs_low), 32'(34 * div));
    check_val("ready_lat",  32'(lat), 32'(FRAME * div));
    check_val("busy_cyc",   32'(busy_n), 32'(FRAME * div));
    check_val("sclk_hi_min", 32'(hi_min), 32'(div));
    check_val("sclk_hi_max", 32'(hi_max), 32'(div));
    check_val("sclk_lo_min", 32'(lo_min), 32'(div));
    check_val("sclk_lo_max", 32'(lo_max), 32'(div));
    if (LDAC_EN) begin
      check_val("ldac_low_cyc", 32'(ld_low), 32'(div));
      check_val("ldac_start",   32'(ld_first), 32'(cs_last + 1));
    end else begin
      check_val("ldac_const0",  32'(ld_low), 32'(lat + 1));
    end
    $display("frame dut%0d div=%0d word=%04h exp=%04h rises=%0d cs_low=%0d lat=%0d",
             k, div, word, exp_w, rises, cs_low, lat);
  endtask

  initial begin
    int dev;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      smp[i]   = 12'd0;
      vld[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // Reset state and quiet idle.
    check_val("rst_ready", 32'(rdy[0]),  32'd1);
    check_val("rst_busy",  32'(bsy[0]),  32'd0);
    check_val("rst_cs_n",  32'(csn[0]),  32'd1);
    check_val("rst_sclk",  32'(sclk[0]), 32'd0);
    check_val("rst_mosi",  32'(mosi[0]), 32'd0);
    check_val("rst_ldac",  32'(ldn[0]),  32'(LDAC_EN));
    dev = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({rdy[0], bsy[0], sclk[0], csn[0], mosi[0], ldn[0]} !==
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, LDAC_EN}) dev++;
    end
    check_val("idle_const", 32'(dev), 32'd0);
    $display("idle dut0 100 cycles deviations=%0d", dev);

    // Single frame, CLK_DIV=2.
    start(0, 12'hA5C);
    monitor(0, 2, 16'h3A5C, 1'b0, 12'h000, 0);

    // Back-to-back with valid held, CLK_DIV=1.
    start(1, 12'h000);
    monitor(1, 1, 16'h3000, 1'b1, 12'hFFF, 0);
    monitor(1, 1, 16'h3FFF, 1'b1, 12'h800, 0);
    monitor(1, 1, 16'h3800, 1'b0, 12'h000, 0);
    repeat (5) @(negedge clk);
    check_val("no_repeat_busy", 32'(bsy[1]), 32'd0);
    check_val("no_repeat_cs_n", 32'(csn[1]), 32'd1);

    // Async reset at the 7th SCLK rise, then a clean frame.
    @(negedge clk);
    start(0, 12'h123);
    monitor(0, 2, 16'h3123, 1'b0, 12'h000, 7);
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    start(0, 12'h456);
    monitor(0, 2, 16'h3456, 1'b0, 12'h000, 0);

    // CLK_DIV=3.
    start(2, 12'h001);
    monitor(2, 3, 16'h3001, 1'b0, 12'h000, 0);

    // CLK_DIV=255: long phases, counter must not wrap early.
    start(3, 12'h7FF);
    monitor(3, 255, 16'h37FF, 1'b0, 12'h000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Downstream stage of the function generator core: consumes 12-bit DAC codes and serialises each one as a 16-bit SPI write frame to an external 12-bit serial DAC (MCP4921-style command word).
- Accepts samples over a valid/ready handshake and drives SCLK, CS_n, MOSI and LDAC_n.
- Sample rate is set by the upstream producer; this block only paces frame timing.

Parameters:
- CLK_DIV, 2, SCLK half-period in sys_clk_i cycles; legal range 1..255; 0 is illegal.
- CFG_BITS, 4'b0011, command nibble sent ahead of the data (channel A, unbuffered, gain 1x, active).

Ports:
- sys_clk_i  input  1  system clock; all logic on its rising edge.
- sys_rst_n_i  input  1  asynchronous active-low reset.
- sample_i  input  12  DAC code.
- sample_valid_i  input  1  sample_i is valid.
- sample_ready_o  output  1  block can accept a sample this cycle.
- busy_o  output  1  frame in progress (any state other than IDLE).
- dac_sclk_o  output  1  SPI clock; idles low; MOSI is sampled by the DAC on the rising edge.
- dac_cs_n_o  output  1  SPI chip select, active low.
- dac_mosi_o  output  1  SPI data, MSB first.
- dac_ldac_n_o  output  1  DAC latch strobe, active low.

Behaviour:
- Reset (async assert, sync to clock on release): state=IDLE, sample_ready_o=1, busy_o=0, dac_sclk_o=0, dac_cs_n_o=1, dac_mosi_o=0, dac_ldac_n_o=1, shift register=0, counters=0.
- Reset asserted mid-frame aborts the frame immediately. CS_n goes high combinationally with reset, via async flop reset. No partial data is retained.
- All outputs are registered.
- Handshake: transfer occurs when sample_valid_i && sample_ready_o on a clock edge. sample_ready_o=1 only in IDLE.
- Valid held while not ready is neither dropped nor double-sent. sample_i is latched at the transfer edge; later changes are ignored.
- Frame word = {CFG_BITS, sample_i}, 16 bits, shifted MSB first.
- A half-period counter (8 bits) counts 0..CLK_DIV-1. A bit counter (5 bits) counts the 16 bits.
- State IDLE: CS_n=1, SCLK=0. On transfer, go to SETUP next cycle with CS_n=0 and MOSI=word[15].
- State SETUP: CLK_DIV cycles, CS_n=0, SCLK=0. Then go to SHIFT.
- State SHIFT: per bit, SCLK=1 for CLK_DIV cycles, then SCLK=0 for CLK_DIV cycles.
  - MOSI advances to the next bit on each falling SCLK edge, except after the 16th bit, where it holds.
  - Exactly 16 rising SCLK edges per frame.
  - After the 16th low phase, go to HOLD.
- State HOLD: CLK_DIV cycles, CS_n=0, SCLK=0. Then CS_n=1 and go to LDAC.
  - CS_n total low time per frame = 34*CLK_DIV cycles.
- State LDAC: LDAC_n=0 for CLK_DIV cycles, CS_n=1. Then go to GAP.
- State GAP: CLK_DIV cycles, all strobes inactive. Then go to IDLE with ready=1; MOSI returns to 0.
- Throughput: with valid held high continuously, consecutive transfers are 36*CLK_DIV+1 cycles apart (35*CLK_DIV+1 without the optional feature).
- busy_o=1 from the cycle after the transfer through the last GAP cycle.
- CLK_DIV=1: SCLK = sys_clk/2. All phase lengths are 1 cycle; no state may be skipped.

Optional Feature:
- Macro: DAC_SPI_TX_LDAC_EN.
- Defined: the LDAC state exists as described above and dac_ldac_n_o pulses low once per frame.
- Undefined: the LDAC state is removed (HOLD goes directly to GAP). dac_ldac_n_o is tied to 0, so the DAC updates on the CS_n rising edge. Frame length is 35*CLK_DIV.

Test Plan:
- Reset then idle, CLK_DIV=2, macro defined -> ready=1, busy=0, CS_n=1, SCLK=0, LDAC_n=1, MOSI=0; outputs stay constant for 100 cycles with valid=0.
- Single sample 12'hA5C, CLK_DIV=2 -> MOSI bits on SCLK rising edges = 16'h3A5C; 16 SCLK rising edges; CS_n low exactly 68 cycles; LDAC_n low 2 cycles starting 1 cycle after CS_n rises; ready returns 72 cycles after the transfer.
- Valid held high with samples 12'h000, 12'hFFF, 12'h800, CLK_DIV=1 -> frames 16'h3000, 16'h3FFF, 16'h3800 in order; transfers 37 cycles apart; no sample lost or repeated; sample_i changed mid-frame has no effect.
- Async reset asserted at the 7th SCLK rising edge of a frame for 12'h123 -> CS_n=1, SCLK=0, ready=1 with no clock edge needed; next sample 12'h456 is sent as a complete 16'h3456 frame.
- Macro undefined, CLK_DIV=3, sample 12'h001 -> frame 16'h3001; LDAC_n constantly 0; CS_n low 102 cycles; transfer-to-ready 105 cycles.
- CLK_DIV=255, sample 12'h7FF -> SCLK high and low phases are each 255 cycles; frame 16'h37FF; the 8-bit half-period counter does not wrap early.
